// File: rtl/apb_regfile_ws_if.sv
// APB bus bundle for apb_regfile_ws: master drives the request, slave returns completion.
interface apb_regfile_ws_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [31:0]           paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regfile_ws.sv
// APB slave register file with wait states, byte strobes, read-only/privileged masks
// and a hardware-side register view with per-register write pulses.
module apb_regfile_ws #(
  parameter logic [31:0]       BASE_ADDR   = 32'h0,
  parameter int unsigned       DATA_WIDTH  = 32,
  parameter int unsigned       N_REGS      = 8,
  parameter int unsigned       WAIT_STATES = 0,
  parameter logic [N_REGS-1:0] RO_MASK     = '0,
  parameter logic [N_REGS-1:0] PRIV_MASK   = '0
) (
  input  logic                         i_pclk,
  input  logic                         i_preset,
  apb_regfile_ws_if.slave              bus,
  output logic [N_REGS*DATA_WIDTH-1:0] o_reg_out,
  output logic [N_REGS-1:0]            o_wr_pulse
);
  localparam int unsigned STRIDE = DATA_WIDTH / 8;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRIDE);
  localparam int unsigned IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [WCNT_W-1:0]     w_wcnt_n;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_regs [N_REGS];
  logic [N_REGS-1:0]     r_wr_pulse;
  logic                  w_setup;
  logic                  w_done;
  logic [31:0]           w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_aligned;
  logic                  w_err;
  logic                  w_unused;

  // Address decode and error classification, evaluated during the setup phase
  assign w_off      = bus.paddr - BASE_ADDR;
  assign w_idx      = IDX_W'(w_off >> OFF_W);
  assign w_in_range = (bus.paddr >= BASE_ADDR) && (w_off < 32'(N_REGS * STRIDE));
  assign w_aligned  = (bus.paddr[OFF_W-1:0] == '0);
  assign w_err      = !w_in_range || !w_aligned ||
                      (bus.pwrite && RO_MASK[w_idx]) ||
                      (PRIV_MASK[w_idx] && !bus.pprot[0]);
  assign w_unused   = ^bus.pprot[2:1];

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_wcnt  <= w_wcnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt;
    w_setup   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.psel && !bus.penable) begin
          w_state_n = S_ACCESS;
          w_wcnt_n  = WCNT_W'(WAIT_STATES);
          w_setup   = 1'b1;
        end
      end
      S_ACCESS: begin
        // Dropping psel mid-access abandons the transfer silently
        if (!bus.psel) begin
          w_state_n = S_IDLE;
        end else if (bus.penable) begin
          if (r_wcnt != '0) begin
            w_wcnt_n = r_wcnt - WCNT_W'(1);
          end else begin
            w_done    = 1'b1;
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_write    <= 1'b0;
      r_wr_pulse <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
        r_regs[i] <= DATA_WIDTH'(i);
      end
    end else begin
      r_wr_pulse <= '0;
      if (w_setup) begin
        r_idx   <= w_idx;
        r_err   <= w_err;
        r_write <= bus.pwrite;
      end
      // Write data and strobes are taken on the completing edge
      if (w_done && r_write && !r_err) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (bus.pstrb[b]) begin
            r_regs[r_idx][8*b +: 8] <= bus.pwdata[8*b +: 8];
          end
        end
        r_wr_pulse[r_idx] <= 1'b1;
      end
    end
  end

  assign bus.pready  = w_done;
  assign bus.pslverr = w_done && r_err;
  assign bus.prdata  = (w_done && !r_err && !r_write) ? r_regs[r_idx] : '0;

  assign o_wr_pulse = r_wr_pulse;

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
    assign o_reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end
endmodule

// File: tb/tb_apb_regfile_ws.sv
// Self-checking bench for apb_regfile_ws: directed vector table, abort/reset sequences
// and randomized transfers checked against a register-array reference model.
module tb_apb_regfile_ws;
  localparam logic [31:0] BASE = 32'h100;
  localparam int unsigned NR   = 8;
  localparam int unsigned WS   = 3;
  localparam logic [7:0]  RO   = 8'h08;
  localparam logic [7:0]  PRIV = 8'h20;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  m_regs [NR];

  apb_regfile_ws_if #(.DATA_WIDTH(32)) bus ();

  apb_regfile_ws #(
    .BASE_ADDR(BASE), .DATA_WIDTH(32), .N_REGS(NR), .WAIT_STATES(WS),
    .RO_MASK(RO), .PRIV_MASK(PRIV)
  ) dut (
    .i_pclk(clk), .i_preset(rst), .bus(bus), .o_reg_out(reg_out), .o_wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
    logic        e;
    logic [31:0] rd;
    logic [7:0]  pulse;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic w, input logic [2:0] p);
    int unsigned off;
    if (a < BASE || a >= BASE + NR * 4) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    off = (a - BASE) / 4;
    if (w && RO[off]) return 1'b1;
    if (PRIV[off] && !p[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned m_off(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 32'(i);
  endtask

  task automatic m_apply(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    if (w && !m_err(a, w, p)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_regs[m_off(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  function automatic logic [255:0] m_pack();
    logic [255:0] r;
    for (int i = 0; i < NR; i++) r[i*32 +: 32] = m_regs[i];
    return r;
  endfunction

  // One full APB transfer with completion, data, pulse and register-view checks
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input logic exp_err,
                      input logic [31:0] exp_rd, input logic [7:0] exp_pulse, input string tag);
    int          cyc;
    logic        got;
    logic        quiet;
    logic [31:0] rd;
    logic        err;
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwrite = w;
    bus.pwdata = d; bus.pstrb = s; bus.pprot = p;
    #1 quiet = (bus.pready === 1'b0) && (bus.prdata === 32'h0) && (bus.pslverr === 1'b0);
    @(negedge clk);
    bus.penable = 1'b1;
    cyc = 0; got = 1'b0; rd = '0; err = 1'b0;
    while (!got && cyc < 40) begin
      #1 cyc++;
      if (bus.pready === 1'b1) begin
        got = 1'b1; rd = bus.prdata; err = bus.pslverr;
      end else begin
        if (bus.prdata !== 32'h0 || bus.pslverr !== 1'b0) quiet = 1'b0;
        @(negedge clk);
      end
    end
    check({tag, "/completed"}, 256'(got), 256'(1));
    if (!got) begin
      bus.psel = 1'b0; bus.penable = 1'b0;
      return;
    end
    check({tag, "/latency"}, 256'(cyc), 256'(WS + 1));
    check({tag, "/quiet_outputs"}, 256'(quiet), 256'(1));
    check({tag, "/pslverr"}, 256'(err), 256'(exp_err));
    check({tag, "/prdata"}, 256'(rd), 256'(exp_rd));
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    m_apply(a, w, d, s, p);
    #1;
    check({tag, "/wr_pulse"}, 256'(wr_pulse), 256'(exp_pulse));
    check({tag, "/reg_out"}, reg_out, m_pack());
    @(negedge clk);
    #1 check({tag, "/wr_pulse_clear"}, 256'(wr_pulse), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [16];
    logic [31:0] a;
    logic        w, e, ok;
    logic [2:0]  p;
    logic [31:0] erd;
    logic [7:0]  ep;

    tbl[0]  = '{32'h104, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0, 32'h0,        8'h02};
    tbl[1]  = '{32'h104, 1'b0, 32'h0,        4'h0, 3'd0, 1'b0, 32'hDEADBEEF, 8'h00};
    tbl[2]  = '{32'h108, 1'b1, 32'h11223344, 4'hF, 3'd0, 1'b0, 32'h0,        8'h04};
    tbl[3]  = '{32'h108, 1'b1, 32'hAABBCCDD, 4'h5, 3'd0, 1'b0, 32'h0,        8'h04};
    tbl[4]  = '{32'h108, 1'b0, 32'h0,        4'h0, 3'd0, 1'b0, 32'h11BB33DD, 8'h00};
    tbl[5]  = '{32'h0FC, 1'b0, 32'h0,        4'h0, 3'd1, 1'b1, 32'h0,        8'h00};
    tbl[6]  = '{32'h120, 1'b1, 32'h12345678, 4'hF, 3'd1, 1'b1, 32'h0,        8'h00};
    tbl[7]  = '{32'h102, 1'b1, 32'h12345678, 4'hF, 3'd1, 1'b1, 32'h0,        8'h00};
    tbl[8]  = '{32'h10C, 1'b1, 32'h12345678, 4'hF, 3'd1, 1'b1, 32'h0,        8'h00};
    tbl[9]  = '{32'h10C, 1'b0, 32'h0,        4'h0, 3'd0, 1'b0, 32'h3,        8'h00};
    tbl[10] = '{32'h114, 1'b0, 32'h0,        4'h0, 3'd0, 1'b1, 32'h0,        8'h00};
    tbl[11] = '{32'h114, 1'b0, 32'h0,        4'h0, 3'd1, 1'b0, 32'h5,        8'h00};
    tbl[12] = '{32'h114, 1'b1, 32'h00000055, 4'hF, 3'd1, 1'b0, 32'h0,        8'h20};
    tbl[13] = '{32'h110, 1'b1, 32'hFFFFFFFF, 4'h0, 3'd0, 1'b0, 32'h0,        8'h10};
    tbl[14] = '{32'h110, 1'b0, 32'h0,        4'h0, 3'd0, 1'b0, 32'h4,        8'h00};
    tbl[15] = '{32'h114, 1'b0, 32'h0,        4'h0, 3'd1, 1'b0, 32'h55,       8'h00};

    rst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
    bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    m_reset();
    @(negedge clk);
    #1;
    check("reset/pready", 256'(bus.pready), 256'(0));
    check("reset/prdata", 256'(bus.prdata), 256'(0));
    check("reset/pslverr", 256'(bus.pslverr), 256'(0));
    check("reset/wr_pulse", 256'(wr_pulse), 256'(0));
    check("reset/reg_out", reg_out, m_pack());
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NR; i++)
      xfer(BASE + 32'(4 * i), 1'b0, 32'h0, 4'h0, 3'd1, 1'b0, 32'(i), 8'h00,
           $sformatf("rst_read%0d", i));

    for (int i = 0; i < 16; i++)
      xfer(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].p, tbl[i].e, tbl[i].rd,
           tbl[i].pulse, $sformatf("tbl%0d", i));

    // psel dropped mid-access: transfer abandoned, no write
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h118; bus.pwrite = 1'b1;
    bus.pwdata = 32'hCAFEF00D; bus.pstrb = 4'hF; bus.pprot = 3'd0;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 if (bus.pready !== 1'b0 || wr_pulse !== 8'h0) ok = 1'b0;
      @(negedge clk);
    end
    check("abort/no_pready_no_pulse", 256'(ok), 256'(1));
    check("abort/reg_out", reg_out, m_pack());
    xfer(32'h118, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h6, 8'h00, "abort_read");
    xfer(32'h118, 1'b1, 32'h600D600D, 4'hF, 3'd0, 1'b0, 32'h0, 8'h40, "abort_write");

    // Reset during a waited write
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h104; bus.pwrite = 1'b1;
    bus.pwdata = 32'h12345678; bus.pstrb = 4'hF; bus.pprot = 3'd1;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    check("midrst/pready", 256'(bus.pready), 256'(0));
    check("midrst/reg_out", reg_out, m_pack());
    check("midrst/wr_pulse", 256'(wr_pulse), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 if (bus.pready !== 1'b0 || wr_pulse !== 8'h0) ok = 1'b0;
      @(negedge clk);
    end
    check("midrst/quiet_after", 256'(ok), 256'(1));
    check("midrst/reg_out_after", reg_out, m_pack());
    bus.psel = 1'b0; bus.penable = 1'b0;
    xfer(32'h104, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 32'h1, 8'h00, "midrst_read");

    // Randomized transfers against the reference model
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) < 7) a = BASE + 32'(4 * $urandom_range(0, NR - 1));
      else                          a = 32'h0F0 + 32'($urandom_range(0, 63));
      w   = 1'($urandom_range(0, 1));
      p   = 3'($urandom_range(0, 7));
      e   = m_err(a, w, p);
      erd = (!w && !e) ? m_regs[m_off(a)] : 32'h0;
      ep  = (w && !e) ? 8'(1 << m_off(a)) : 8'h00;
      xfer(a, w, $urandom, 4'($urandom_range(0, 15)), p, e, erd, ep,
           $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
